dts_multi_offsetter: RTL and testbench
======================================

Name: dts_multi_offsetter

Overview:
- N-channel, single-clock programmable delay line for deformatted DTS streams.
- Each channel carries DATA_WIDTH data bits plus one_sec/ten_sec/index/sync sidebands through a per-channel adjustable delay.
- Delay is set by manual advance/delay strobes or by a hardware auto-align that equalises sync arrival across channels.
- Sits after the per-link deformatters and before channel combining; successor of the dual-clock single-channel FIFO offsetter.

Parameters:
- N_CHANNELS, 4, number of independent DTS streams.
- DATA_WIDTH, 128, data bits per channel per cycle.
- DEPTH_BITS, 5, log2 of delay-line depth; max delay DMAX = 2**DEPTH_BITS-2.
- TIMEOUT_BITS, 16, width of the auto-align capture timer; timeout = 2**TIMEOUT_BITS-1 cycles.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  N_CHANNELS*DATA_WIDTH  channel c at slice [c*DATA_WIDTH +: DATA_WIDTH].
- din_one_sec, din_ten_sec, din_index, din_sync  in  N_CHANNELS each  per-channel sidebands.
- advance  in  N_CHANNELS  rising edge: reduce channel delay by 1.
- delay  in  N_CHANNELS  rising edge: increase channel delay by 1.
- align_req  in  1  rising edge starts auto-align.
- dout  out  N_CHANNELS*DATA_WIDTH  delayed data.
- dout_one_sec, dout_ten_sec, dout_index, dout_sync  out  N_CHANNELS each  delayed sidebands.
- delay_cur  out  N_CHANNELS*DEPTH_BITS  current per-channel delay setting.
- primed  out  1  high once the delay line holds valid history.
- align_busy  out  1  auto-align in progress.
- align_done  out  1  one-cycle pulse on successful align.
- align_err  out  1  sticky; cleared by the next align_req edge.

Behaviour:
- Reset (async assert, sync deassert internally via 2-FF):
  - all outputs 0; delay_cur all 0; write pointer 0; edge-detect registers 0; FSM IDLE.
- Write side:
  - Shared write pointer advances every cycle, wrapping modulo 2**DEPTH_BITS.
  - Each channel's {sidebands, data} word is written every cycle.
- Read side:
  - Read address = wr_ptr - 1 - delay_c; registered RAM read plus output register.
  - Total latency din→dout = 2 + delay_c cycles.
- Priming:
  - A counter runs 2**DEPTH_BITS cycles after reset; primed then goes high and stays high.
  - While primed=0, dout and all dout sidebands are forced to 0.
- Manual adjust (only while align_busy=0):
  - Rising edges are detected per channel.
  - delay edge: delay_c+1, saturating at DMAX. advance edge: delay_c-1, saturating at 0.
  - Both edges in the same cycle: no change.
  - Edges arriving while busy are discarded, not queued.
  - On a delay change, the output skips or repeats words for one cycle only; it never shows X.
- Auto-align FSM:
  - IDLE: align_req edge → ARM; clear align_err.
  - ARM (1 cycle): clear captured flags and timer → CAPTURE.
  - CAPTURE: timer increments each cycle. On the first din_sync of channel c, record t_c = timer and set flag_c.
    - All flags set → COMPUTE.
    - Timer reaches all-ones first → ERR.
    - A sync on a channel already captured is ignored.
    - A channel whose sync coincides with the cycle all flags complete still counts.
  - COMPUTE (2 cycles, pipelined max/min): tmax = max t_c, tmin = min t_c.
    - If tmax - tmin > DMAX → ERR.
    - Otherwise delay_c = tmax - t_c, using DEPTH_BITS-bit truncation after the range check → DONE.
  - DONE: align_done=1 for one cycle → IDLE.
  - ERR: set align_err; delays unchanged → IDLE.
  - align_busy=1 in ARM, CAPTURE and COMPUTE.
  - align_req edges while busy are ignored.
- Reset mid-align: FSM returns to IDLE, delays return to 0, primed returns to 0.
- The timer is unsigned and non-wrapping; the error arithmetic uses TIMEOUT_BITS+1 bits.

Decomposition:
- Shared package dts_pkg:
  - sideband bit-index constants (SYNC=0, INDEX=1, TEN_SEC=2, ONE_SEC=3; word = {sb[3:0], data});
  - align FSM state enum;
  - function clog2.
- Sub-module dts_delay_line:
  - one channel's RAM (width DATA_WIDTH+4, depth 2**DEPTH_BITS);
  - read-address subtract and output register;
  - instantiated N_CHANNELS times in a generate loop.
- Top level holds the write pointer, priming counter, edge detectors, delay registers and align FSM.

Test Plan:
- Reset, then counting pattern on all channels, N=4, DEPTH_BITS=5 → primed rises after 32 cycles; dout_c = din_c delayed exactly 2 cycles; outputs 0 before primed.
- Channel 1: 3 delay edges, then 5 advance edges → delay_cur[1] shows 1,2,3 then down to 0, saturating with no underflow; dout latency matches 2+delay_c after each step.
- Channel 0: 40 delay edges → delay_cur saturates at 30; advance and delay edges in the same cycle → no change.
- Syncs at capture times t = 10, 13, 17, 12 → align_done pulse; delay_cur = 7, 4, 0, 5; dout_sync coincides on all channels thereafter.
- Syncs spread by 31 cycles (t = 5 and 36) → align_err=1, delays unchanged; the next align_req edge clears align_err.
- Channel 3 sync missing with TIMEOUT_BITS=6 → align_err after 63 capture cycles. A separate run asserts rst_n=0 during CAPTURE → all outputs 0 and FSM IDLE immediately.

Source files
------------

// File: rtl/dts_pkg.sv
// Shared definitions for the multi-channel DTS offsetter: sideband layout,
// align FSM states and a constant-function log2 helper.
package dts_pkg;

    // Stored word layout is {sb[3:0], data}; these index sb.
    localparam int unsigned SB_SYNC    = 0;
    localparam int unsigned SB_INDEX   = 1;
    localparam int unsigned SB_TEN_SEC = 2;
    localparam int unsigned SB_ONE_SEC = 3;
    localparam int unsigned SB_BITS    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_COMP1,
        ST_COMP2,
        ST_DONE,
        ST_ERR
    } align_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned result;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dts_delay_line.sv
// One channel of the offsetter: circular word RAM written every cycle,
// read at wr_ptr-1-delay through a registered read and an output register.
module dts_delay_line
    import dts_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH_BITS = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DEPTH_BITS-1:0]          i_wr_ptr,
    input  logic [DEPTH_BITS-1:0]          i_delay,
    input  logic                           i_valid,
    input  logic [DATA_WIDTH+SB_BITS-1:0]  i_word,
    output logic [DATA_WIDTH+SB_BITS-1:0]  o_word
);

    localparam int unsigned WORD_W = DATA_WIDTH + SB_BITS;
    localparam int unsigned DEPTH  = 2**DEPTH_BITS;

    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic [WORD_W-1:0]     r_rd_word;
    logic [WORD_W-1:0]     r_out;
    logic [DEPTH_BITS-1:0] w_rd_addr;

    // Storage carries no reset; priming hides the unwritten history.
    always_ff @(posedge clk) begin
        r_mem[i_wr_ptr] <= i_word;
    end

    assign w_rd_addr = i_wr_ptr - DEPTH_BITS'(1) - i_delay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_word <= '0;
            r_out     <= '0;
        end else begin
            r_rd_word <= r_mem[w_rd_addr];
            r_out     <= i_valid ? r_rd_word : '0;
        end
    end

    assign o_word = r_out;

endmodule

// File: rtl/dts_multi_offsetter.sv
// N-channel programmable delay line for deformatted DTS streams with manual
// advance/delay trim and a sync-based hardware auto-align.
module dts_multi_offsetter
    import dts_pkg::*;
#(
    parameter int unsigned N_CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned DEPTH_BITS   = 5,
    parameter int unsigned TIMEOUT_BITS = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] din,
    input  logic [N_CHANNELS-1:0]            din_one_sec,
    input  logic [N_CHANNELS-1:0]            din_ten_sec,
    input  logic [N_CHANNELS-1:0]            din_index,
    input  logic [N_CHANNELS-1:0]            din_sync,
    input  logic [N_CHANNELS-1:0]            advance,
    input  logic [N_CHANNELS-1:0]            delay,
    input  logic                             align_req,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] dout,
    output logic [N_CHANNELS-1:0]            dout_one_sec,
    output logic [N_CHANNELS-1:0]            dout_ten_sec,
    output logic [N_CHANNELS-1:0]            dout_index,
    output logic [N_CHANNELS-1:0]            dout_sync,
    output logic [N_CHANNELS*DEPTH_BITS-1:0] delay_cur,
    output logic                             primed,
    output logic                             align_busy,
    output logic                             align_done,
    output logic                             align_err
);

    localparam int unsigned DEPTH   = 2**DEPTH_BITS;
    localparam int unsigned DMAX    = DEPTH - 2;
    localparam int unsigned WORD_W  = DATA_WIDTH + SB_BITS;
    localparam int unsigned PRIME_W = clog2(DEPTH) + 1;
    localparam int unsigned SPAN_W  = TIMEOUT_BITS + 1;

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;
    logic [DEPTH_BITS-1:0]   r_wr_ptr;
    logic [PRIME_W-1:0]      r_prime_cnt;
    logic [N_CHANNELS-1:0]   r_adv_q;
    logic [N_CHANNELS-1:0]   r_dly_q;
    logic                    r_req_q;
    logic [N_CHANNELS-1:0]   w_adv_rise;
    logic [N_CHANNELS-1:0]   w_dly_rise;
    logic                    w_req_rise;
    logic [DEPTH_BITS-1:0]   r_delay [N_CHANNELS];

    align_state_e            r_state;
    align_state_e            w_state_next;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [TIMEOUT_BITS-1:0] r_timer;
    logic [TIMEOUT_BITS-1:0] r_t [N_CHANNELS];
    logic [N_CHANNELS-1:0]   r_flags;
    logic [N_CHANNELS-1:0]   w_cap_new;
    logic                    w_flags_all;
    logic                    w_timer_full;
    logic [TIMEOUT_BITS-1:0] w_tmax;
    logic [TIMEOUT_BITS-1:0] w_tmin;
    logic [TIMEOUT_BITS-1:0] r_tmax;
    logic [TIMEOUT_BITS-1:0] r_tmin;
    logic [SPAN_W-1:0]       w_spread;
    logic                    w_spread_bad;
    logic                    w_apply;

    // Async assert, synchronous release of the internal reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Shared write pointer, priming counter and strobe edge history.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr    <= '0;
            r_prime_cnt <= '0;
            r_adv_q     <= '0;
            r_dly_q     <= '0;
            r_req_q     <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            if (!r_prime_cnt[PRIME_W-1]) begin
                r_prime_cnt <= r_prime_cnt + PRIME_W'(1);
            end
            r_adv_q <= advance;
            r_dly_q <= delay;
            r_req_q <= align_req;
        end
    end

    assign primed     = r_prime_cnt[PRIME_W-1];
    assign w_adv_rise = advance & ~r_adv_q;
    assign w_dly_rise = delay & ~r_dly_q;
    assign w_req_rise = align_req & ~r_req_q;

    assign w_cap_new    = (r_state == ST_CAPTURE) ? (din_sync & ~r_flags) : '0;
    assign w_flags_all  = &(r_flags | w_cap_new);
    assign w_timer_full = &r_timer;

    always_comb begin
        w_tmax = '0;
        w_tmin = '1;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (r_t[c] > w_tmax) w_tmax = r_t[c];
            if (r_t[c] < w_tmin) w_tmin = r_t[c];
        end
    end

    assign w_spread     = SPAN_W'(r_tmax) - SPAN_W'(r_tmin);
    assign w_spread_bad = w_spread > SPAN_W'(DMAX);
    assign w_apply      = (r_state == ST_COMP2) && !w_spread_bad;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_req_rise) w_state_next = ST_ARM;
            ST_ARM:     w_state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (w_flags_all)       w_state_next = ST_COMP1;
                else if (w_timer_full) w_state_next = ST_ERR;
            end
            ST_COMP1:   w_state_next = ST_COMP2;
            ST_COMP2:   w_state_next = w_spread_bad ? ST_ERR : ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            ST_ERR:     w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_ARM) || (w_state_next == ST_CAPTURE) ||
                       (w_state_next == ST_COMP1) || (w_state_next == ST_COMP2);
            r_done  <= (w_state_next == ST_DONE);
            if (w_state_next == ST_ERR) begin
                r_err <= 1'b1;
            end else if ((r_state == ST_IDLE) && w_req_rise) begin
                r_err <= 1'b0;
            end
        end
    end

    // Sync capture timer and per-channel first-sync timestamps.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_timer <= '0;
            r_flags <= '0;
            r_tmax  <= '0;
            r_tmin  <= '0;
            for (int c = 0; c < N_CHANNELS; c++) r_t[c] <= '0;
        end else begin
            if (r_state == ST_ARM) begin
                r_timer <= '0;
                r_flags <= '0;
            end else if (r_state == ST_CAPTURE) begin
                if (!w_timer_full) r_timer <= r_timer + TIMEOUT_BITS'(1);
                for (int c = 0; c < N_CHANNELS; c++) begin
                    if (w_cap_new[c]) begin
                        r_t[c]     <= r_timer;
                        r_flags[c] <= 1'b1;
                    end
                end
            end
            if (r_state == ST_COMP1) begin
                r_tmax <= w_tmax;
                r_tmin <= w_tmin;
            end
        end
    end

    // Delay settings: align result wins; manual strobes only when not busy.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int c = 0; c < N_CHANNELS; c++) r_delay[c] <= '0;
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (w_apply) begin
                    r_delay[c] <= DEPTH_BITS'(r_tmax - r_t[c]);
                end else if (!r_busy) begin
                    if (w_dly_rise[c] && !w_adv_rise[c] && (r_delay[c] != DEPTH_BITS'(DMAX))) begin
                        r_delay[c] <= r_delay[c] + DEPTH_BITS'(1);
                    end else if (w_adv_rise[c] && !w_dly_rise[c] && (r_delay[c] != '0)) begin
                        r_delay[c] <= r_delay[c] - DEPTH_BITS'(1);
                    end
                end
            end
        end
    end

    assign align_busy = r_busy;
    assign align_done = r_done;
    assign align_err  = r_err;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        logic [WORD_W-1:0] w_wr_word;
        logic [WORD_W-1:0] w_rd_word;

        assign w_wr_word = {din_one_sec[c], din_ten_sec[c], din_index[c], din_sync[c],
                            din[c*DATA_WIDTH +: DATA_WIDTH]};

        dts_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH_BITS (DEPTH_BITS)
        ) u_line (
            .clk      (clk),
            .rst_n    (w_rst_n),
            .i_wr_ptr (r_wr_ptr),
            .i_delay  (r_delay[c]),
            .i_valid  (primed),
            .i_word   (w_wr_word),
            .o_word   (w_rd_word)
        );

        assign dout[c*DATA_WIDTH +: DATA_WIDTH] = w_rd_word[DATA_WIDTH-1:0];
        assign dout_sync[c]    = w_rd_word[DATA_WIDTH + SB_SYNC];
        assign dout_index[c]   = w_rd_word[DATA_WIDTH + SB_INDEX];
        assign dout_ten_sec[c] = w_rd_word[DATA_WIDTH + SB_TEN_SEC];
        assign dout_one_sec[c] = w_rd_word[DATA_WIDTH + SB_ONE_SEC];
        assign delay_cur[c*DEPTH_BITS +: DEPTH_BITS] = r_delay[c];
    end

endmodule

// File: tb/tb_dts_multi_offsetter.sv
// Self-checking bench: random words and sidebands recorded in a history array;
// expected outputs are looked up at (cycle - 3 - delay) from a per-channel delay model.
module tb_dts_multi_offsetter;

    localparam int NC   = 4;
    localparam int DW   = 128;
    localparam int DB   = 5;
    localparam int TOB  = 6;
    localparam int HN   = 256;
    localparam int DMAX = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC*DW-1:0]  din;
    logic [NC-1:0]     din_one_sec, din_ten_sec, din_index, din_sync;
    logic [NC-1:0]     advance, delay;
    logic              align_req;
    logic [NC*DW-1:0]  dout;
    logic [NC-1:0]     dout_one_sec, dout_ten_sec, dout_index, dout_sync;
    logic [NC*DB-1:0]  delay_cur;
    logic              primed, align_busy, align_done, align_err;

    always #5 clk = ~clk;

    dts_multi_offsetter #(
        .N_CHANNELS   (NC),
        .DATA_WIDTH   (DW),
        .DEPTH_BITS   (DB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .din_one_sec  (din_one_sec),
        .din_ten_sec  (din_ten_sec),
        .din_index    (din_index),
        .din_sync     (din_sync),
        .advance      (advance),
        .delay        (delay),
        .align_req    (align_req),
        .dout         (dout),
        .dout_one_sec (dout_one_sec),
        .dout_ten_sec (dout_ten_sec),
        .dout_index   (dout_index),
        .dout_sync    (dout_sync),
        .delay_cur    (delay_cur),
        .primed       (primed),
        .align_busy   (align_busy),
        .align_done   (align_done),
        .align_err    (align_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NC*DW-1:0] h_din  [HN];
    logic [NC-1:0]    h_sync [HN];
    logic [NC-1:0]    h_idx  [HN];
    logic [NC-1:0]    h_ten  [HN];
    logic [NC-1:0]    h_one  [HN];
    int               mdl    [NC];
    logic [NC-1:0]    sync_drv  = '0;
    bit               rand_sync = 1'b1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < NC; c++) din[c*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
        din_one_sec = 4'($urandom());
        din_ten_sec = 4'($urandom());
        din_index   = 4'($urandom());
        din_sync    = rand_sync ? 4'($urandom()) : sync_drv;
        h_din[cyc % HN]  = din;
        h_sync[cyc % HN] = din_sync;
        h_idx[cyc % HN]  = din_index;
        h_ten[cyc % HN]  = din_ten_sec;
        h_one[cyc % HN]  = din_one_sec;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    // A word driven in cycle n is captured at edge n+1 and appears 2+d edges later.
    task automatic check_data(input int n);
        repeat (n) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                int k;
                k = (cyc - 3 - mdl[c]) % HN;
                chk($sformatf("data_ch%0d", c),
                    512'({dout_one_sec[c], dout_ten_sec[c], dout_index[c], dout_sync[c], dout[c*DW +: DW]}),
                    512'({h_one[k][c], h_ten[k][c], h_idx[k][c], h_sync[k][c], h_din[k][c*DW +: DW]}));
            end
        end
    endtask

    task automatic pulse(input bit is_dly, input bit is_adv, input int c, input int nchk);
        tick();
        if (is_dly) delay[c] = 1'b1;
        if (is_adv) advance[c] = 1'b1;
        tick();
        delay[c]   = 1'b0;
        advance[c] = 1'b0;
        if (is_dly && !is_adv && mdl[c] < DMAX) mdl[c]++;
        else if (is_adv && !is_dly && mdl[c] > 0) mdl[c]--;
        tick();
        tick();
        chk($sformatf("delay_cur_ch%0d", c), 512'(delay_cur[c*DB +: DB]), 512'(mdl[c]));
        check_data(nchk);
    endtask

    // Syncs on channel c are driven i==t[c] cycles into the capture window.
    task automatic run_align(input int t0, input int t1, input int t2, input int t3,
                             input logic [NC-1:0] present, input int len,
                             output int done_first, output int err_first, output logic busy_mid);
        int ts [NC];
        ts = '{t0, t1, t2, t3};
        done_first = -1;
        err_first  = -1;
        busy_mid   = 1'b0;
        rand_sync  = 1'b0;
        sync_drv   = '0;
        tick();
        align_req = 1'b1;
        tick();
        align_req = 1'b0;
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < NC; c++) sync_drv[c] = present[c] && (i == ts[c]);
            tick();
            if (i == 3) busy_mid = align_busy;
            if (done_first < 0 && align_done) done_first = i;
            if (err_first < 0 && align_err) err_first = i;
        end
        sync_drv  = '0;
        rand_sync = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          df, ef;
        logic        bm;
        logic [NC-1:0] first_sync;
        bit          seen;
        int          ts2 [NC];

        rst_n = 1'b1; din = '0; din_one_sec = '0; din_ten_sec = '0; din_index = '0; din_sync = '0;
        advance = '0; delay = '0; align_req = 1'b0;
        for (int c = 0; c < NC; c++) mdl[c] = 0;
        #2 rst_n = 1'b0;
        repeat (4) tick();
        chk("rst_dout", 512'(dout), 512'(0));
        chk("rst_sideband", 512'({dout_one_sec, dout_ten_sec, dout_index, dout_sync}), 512'(0));
        chk("rst_delay_cur", 512'(delay_cur), 512'(0));
        chk("rst_status", 512'({primed, align_busy, align_done, align_err}), 512'(0));

        // Priming window: outputs held at zero until primed.
        rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 28) chk("primed_early", 512'(primed), 512'(0));
            if (k == 40) chk("primed_late", 512'(primed), 512'(1));
            if (!primed) begin
                chk("gate_dout", 512'(dout), 512'(0));
                chk("gate_sideband", 512'({dout_one_sec, dout_ten_sec, dout_index, dout_sync}), 512'(0));
            end
        end
        check_data(10);

        // Channel 1 trim up then down past zero.
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1, 2);
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1, 2);

        // Channel 0 saturation, then simultaneous strobes.
        for (int i = 0; i < 40; i++) pulse(1'b1, 1'b0, 0, 0);
        pulse(1'b1, 1'b1, 0, 3);

        // Auto-align with capture times 10,13,17,12.
        run_align(10, 13, 17, 12, 4'hf, 45, df, ef, bm);
        chk("align_done_seen", 512'(df >= 0), 512'(1));
        chk("align_no_err", 512'(ef >= 0), 512'(0));
        chk("align_busy_mid", 512'(bm), 512'(1));
        mdl = '{7, 4, 0, 5};
        for (int c = 0; c < NC; c++)
            chk($sformatf("align_delay_ch%0d", c), 512'(delay_cur[c*DB +: DB]), 512'(mdl[c]));
        check_data(6);

        // Same sync pattern again must emerge on all channels together.
        ts2 = '{10, 13, 17, 12};
        rand_sync = 1'b0;
        sync_drv  = '0;
        repeat (12) tick();
        seen = 1'b0;
        first_sync = '0;
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < NC; c++) sync_drv[c] = (i == ts2[c]);
            tick();
            if (!seen && dout_sync != '0) begin
                seen = 1'b1;
                first_sync = dout_sync;
            end
        end
        sync_drv  = '0;
        rand_sync = 1'b1;
        chk("sync_coincide", 512'(first_sync), 512'(4'hf));

        // Spread of 31 exceeds the maximum delay.
        run_align(5, 36, 20, 20, 4'hf, 45, df, ef, bm);
        chk("spread_err", 512'(ef >= 0), 512'(1));
        chk("spread_no_done", 512'(df >= 0), 512'(0));
        for (int c = 0; c < NC; c++)
            chk($sformatf("spread_delay_ch%0d", c), 512'(delay_cur[c*DB +: DB]), 512'(mdl[c]));
        check_data(4);

        // Missing channel 3 sync: err cleared by the request, set again on timeout.
        run_align(10, 12, 14, 0, 4'b0111, 80, df, ef, bm);
        chk("timeout_window", 512'(ef >= 60 && ef <= 66), 512'(1));
        chk("timeout_no_done", 512'(df >= 0), 512'(0));
        chk("timeout_status", 512'({align_busy, align_err}), 512'(2'b01));

        // Reset asserted mid-capture.
        tick();
        align_req = 1'b1;
        tick();
        align_req = 1'b0;
        repeat (5) tick();
        chk("midrst_busy_before", 512'(align_busy), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", 512'(dout), 512'(0));
        chk("midrst_sideband", 512'({dout_one_sec, dout_ten_sec, dout_index, dout_sync}), 512'(0));
        chk("midrst_delay_cur", 512'(delay_cur), 512'(0));
        chk("midrst_status", 512'({primed, align_busy, align_done, align_err}), 512'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("postrst_idle", 512'({align_busy, align_done, align_err}), 512'(0));
        chk("postrst_delay_cur", 512'(delay_cur), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
